// File: rtl/adsr_envelope.sv
// ADSR-style amplitude envelope: attack/sustain/release level tracking driven by
// the note gate, then scaling of the offset-binary sample stream by that level.
module adsr_envelope #(
  parameter int unsigned SAMPLE_W = 12,
  parameter int unsigned LEVEL_W  = 16
) (
  input  logic                inCLK,
  input  logic                inRST_N,
  input  logic [SAMPLE_W-1:0] inSample,
  input  logic                inSampleReady,
  input  logic                inIsPlaying,
  input  logic [6:0]          inVelocity,
  input  logic [6:0]          inAttack,
  input  logic [6:0]          inRelease,
  output logic [SAMPLE_W-1:0] outSample,
  output logic                outSampleReady,
  output logic [1:0]          outState,
  output logic [LEVEL_W-1:0]  outLevel
);

  localparam int unsigned PROD_W = SAMPLE_W + LEVEL_W + 1;
  localparam logic [SAMPLE_W-1:0] MIDSCALE = {1'b1, {(SAMPLE_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ATTACK  = 2'd1,
    SUSTAIN = 2'd2,
    RELEASE = 2'd3
  } envState_t;

  envState_t            state;
  logic [LEVEL_W-1:0]   level;
  logic [LEVEL_W-1:0]   target;
  logic [LEVEL_W-1:0]   attackStep;
  logic [LEVEL_W-1:0]   releaseStep;
  logic [LEVEL_W:0]     attackSum;

  logic [SAMPLE_W-1:0]  sampleQ;
  logic                 validQ;
  logic signed [PROD_W-1:0] centeredExt;
  logic signed [PROD_W-1:0] levelExt;
  logic signed [PROD_W-1:0] product;

  // Time control 0..127 maps to a per-strobe step of 2048 down to 16.
  function automatic logic [LEVEL_W-1:0] stepOf(input logic [6:0] ctrl);
    logic [7:0] span;
    span = 8'd128 - {1'b0, ctrl};
    return LEVEL_W'({span, 4'b0000});
  endfunction

  // Velocity replicated across the level word so 127 reaches full scale exactly.
  assign target      = LEVEL_W'({inVelocity, inVelocity, inVelocity[6:5]});
  assign attackStep  = stepOf(inAttack);
  assign releaseStep = stepOf(inRelease);
  assign attackSum   = {1'b0, level} + {1'b0, attackStep};

  // Envelope state and level advance once per input sample strobe.
  always_ff @(posedge inCLK) begin
    if (!inRST_N) begin
      state <= IDLE;
      level <= '0;
    end else if (inSampleReady) begin
      case (state)
        IDLE: begin
          level <= '0;
          if (inIsPlaying) state <= ATTACK;
        end
        ATTACK: begin
          if (!inIsPlaying) begin
            state <= RELEASE;
          end else if (attackSum >= {1'b0, target}) begin
            level <= target;
            state <= SUSTAIN;
          end else begin
            level <= attackSum[LEVEL_W-1:0];
          end
        end
        SUSTAIN: begin
          level <= target;
          if (!inIsPlaying) state <= RELEASE;
        end
        RELEASE: begin
          if (inIsPlaying) begin
            state <= ATTACK;
          end else if (level <= releaseStep) begin
            level <= '0;
            state <= IDLE;
          end else begin
            level <= level - releaseStep;
          end
        end
        default: begin
          state <= IDLE;
          level <= '0;
        end
      endcase
    end
  end

  assign outState = state;
  assign outLevel = level;

  // First pipeline stage: hold the sample that arrived with the strobe.
  always_ff @(posedge inCLK) begin
    if (!inRST_N) begin
      sampleQ <= MIDSCALE;
      validQ  <= 1'b0;
    end else begin
      validQ <= inSampleReady;
      if (inSampleReady) sampleQ <= inSample;
    end
  end

  // Offset-binary to two's complement is an MSB flip; level is always non-negative.
  assign centeredExt = {{(PROD_W-SAMPLE_W){~sampleQ[SAMPLE_W-1]}},
                        ~sampleQ[SAMPLE_W-1], sampleQ[SAMPLE_W-2:0]};
  assign levelExt    = {{(PROD_W-LEVEL_W){1'b0}}, level};
  assign product     = centeredExt * levelExt;

  // Second stage: scale by the level this strobe produced, re-bias, and hold between strobes.
  always_ff @(posedge inCLK) begin
    if (!inRST_N) begin
      outSample      <= MIDSCALE;
      outSampleReady <= 1'b0;
    end else begin
      outSampleReady <= validQ;
      if (validQ) outSample <= SAMPLE_W'(product >>> LEVEL_W) + MIDSCALE;
    end
  end

endmodule

// File: tb/tb_adsr_envelope.sv
// Directed bench for adsr_envelope: expected samples queued per strobe and
// checked by an independent monitor; state/level checked right after each strobe.
module tb_adsr_envelope;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ATTACK  = 2'd1;
  localparam logic [1:0] S_SUSTAIN = 2'd2;
  localparam logic [1:0] S_RELEASE = 2'd3;

  logic        inCLK = 1'b0;
  logic        inRST_N = 1'b0;
  logic [11:0] inSample = 12'h800;
  logic        inSampleReady = 1'b0;
  logic        inIsPlaying = 1'b0;
  logic [6:0]  inVelocity = 7'd127;
  logic [6:0]  inAttack = 7'd0;
  logic [6:0]  inRelease = 7'd0;
  logic [11:0] outSample;
  logic        outSampleReady;
  logic [1:0]  outState;
  logic [15:0] outLevel;

  typedef struct {
    logic [11:0] sample;
    int          cycle;
  } expItem_t;

  expItem_t sb[$];
  int cycle = 0;
  int checks = 0;
  int fails = 0;

  adsr_envelope dut (
    .inCLK         (inCLK),
    .inRST_N       (inRST_N),
    .inSample      (inSample),
    .inSampleReady (inSampleReady),
    .inIsPlaying   (inIsPlaying),
    .inVelocity    (inVelocity),
    .inAttack      (inAttack),
    .inRelease     (inRelease),
    .outSample     (outSample),
    .outSampleReady(outSampleReady),
    .outState      (outState),
    .outLevel      (outLevel)
  );

  always #5 inCLK = ~inCLK;

  always @(posedge inCLK) cycle <= cycle + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Monitor: every output strobe must match the oldest pending expectation.
  always @(negedge inCLK) begin
    expItem_t e;
    if (outSampleReady === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_strobe: outSampleReady at cycle %0d with nothing pending", cycle);
      end else begin
        e = sb.pop_front();
        check("out_sample", 32'(outSample), 32'(e.sample));
        check("out_latency", 32'(cycle), 32'(e.cycle));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge inCLK);
    #1;
  endtask

  // One strobe; back-to-back calls keep inSampleReady high across edges.
  task automatic strobe(input logic [11:0] smp, input logic [11:0] expSmp,
                        input logic [1:0] expState, input logic [15:0] expLevel);
    inSample      = smp;
    inSampleReady = 1'b1;
    sb.push_back('{expSmp, cycle + 2});
    @(posedge inCLK);
    #1;
    inSampleReady = 1'b0;
    check("out_state", 32'(outState), 32'(expState));
    check("out_level", 32'(outLevel), 32'(expLevel));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    idle(3);
    check("reset_sample", 32'(outSample), 32'h800);
    check("reset_ready", 32'(outSampleReady), 32'h0);
    check("reset_state", 32'(outState), 32'(S_IDLE));
    check("reset_level", 32'(outLevel), 32'h0);
    inRST_N = 1'b1;
    idle(2);

    // Gate low: full-scale input stays silent
    repeat (3) strobe(12'hFFF, 12'h800, S_IDLE, 16'h0000);
    idle(3);

    // Fast attack at full velocity: 32 steps of 2048
    inIsPlaying = 1'b1;
    strobe(12'hFFF, 12'h800, S_ATTACK, 16'h0000);
    for (int k = 1; k <= 31; k++) strobe(12'h800, 12'h800, S_ATTACK, 16'(k * 2048));
    strobe(12'h800, 12'h800, S_SUSTAIN, 16'hFFFF);

    // Sustain scaling at full level, with gaps and hold check
    strobe(12'hFFF, 12'hFFE, S_SUSTAIN, 16'hFFFF);
    idle(3);
    strobe(12'h800, 12'h800, S_SUSTAIN, 16'hFFFF);
    strobe(12'h000, 12'h000, S_SUSTAIN, 16'hFFFF);
    idle(5);
    check("hold_sample", 32'(outSample), 32'h000);

    // Fast release: 32 strobes back to zero
    inIsPlaying = 1'b0;
    strobe(12'hFFF, 12'hFFE, S_RELEASE, 16'hFFFF);
    for (int k = 1; k <= 31; k++) strobe(12'h800, 12'h800, S_RELEASE, 16'(65535 - k * 2048));
    strobe(12'hFFF, 12'h800, S_IDLE, 16'h0000);
    idle(4);
    check("release_end_sample", 32'(outSample), 32'h800);

    // Retrigger from release at half scale
    inIsPlaying = 1'b1;
    strobe(12'h800, 12'h800, S_ATTACK, 16'h0000);
    for (int k = 1; k <= 16; k++) strobe(12'h800, 12'h800, S_ATTACK, 16'(k * 2048));
    inIsPlaying = 1'b0;
    strobe(12'hFFF, 12'hBFF, S_RELEASE, 16'h8000);
    inIsPlaying = 1'b1;
    strobe(12'h000, 12'h400, S_ATTACK, 16'h8000);
    strobe(12'h800, 12'h800, S_ATTACK, 16'h8800);

    // Attack above target clamps; sustain follows velocity
    inVelocity = 7'd0;
    strobe(12'hFFF, 12'h800, S_SUSTAIN, 16'h0000);
    inVelocity = 7'd64;
    strobe(12'h800, 12'h800, S_SUSTAIN, 16'h8102);
    inVelocity = 7'd0;
    strobe(12'h800, 12'h800, S_SUSTAIN, 16'h0000);
    inIsPlaying = 1'b0;
    strobe(12'h800, 12'h800, S_RELEASE, 16'h0000);
    strobe(12'h800, 12'h800, S_IDLE, 16'h0000);
    idle(3);

    // Slowest attack: 4096 steps of 16
    inVelocity  = 7'd127;
    inAttack    = 7'd127;
    inIsPlaying = 1'b1;
    strobe(12'h800, 12'h800, S_ATTACK, 16'h0000);
    for (int k = 1; k <= 4095; k++) strobe(12'h800, 12'h800, S_ATTACK, 16'(k * 16));
    strobe(12'h800, 12'h800, S_SUSTAIN, 16'hFFFF);

    // Slowest release step, then retrigger into attack
    inRelease   = 7'd127;
    inIsPlaying = 1'b0;
    strobe(12'hFFF, 12'hFFE, S_RELEASE, 16'hFFFF);
    strobe(12'h800, 12'h800, S_RELEASE, 16'hFFEF);
    inIsPlaying = 1'b1;
    strobe(12'h800, 12'h800, S_ATTACK, 16'hFFEF);

    // Reset one cycle after a mid-attack strobe discards it
    inAttack      = 7'd0;
    inSample      = 12'hFFF;
    inSampleReady = 1'b1;
    @(posedge inCLK);
    #1;
    inSampleReady = 1'b0;
    inRST_N       = 1'b0;
    @(posedge inCLK);
    #1;
    check("midreset_ready", 32'(outSampleReady), 32'h0);
    check("midreset_sample", 32'(outSample), 32'h800);
    check("midreset_state", 32'(outState), 32'(S_IDLE));
    check("midreset_level", 32'(outLevel), 32'h0);
    idle(1);
    inRST_N = 1'b1;
    idle(3);

    // First strobes after reset behave normally
    strobe(12'h800, 12'h800, S_ATTACK, 16'h0000);
    strobe(12'hFFF, 12'h83F, S_ATTACK, 16'h0800);
    idle(6);

    check("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
